// File: rtl/demapper.sv
// Receive-side frame demapper: acquires and tracks frame alignment on the line byte
// stream and buffers the valid payload bytes for a valid/ready byte consumer.
module demapper #(
    parameter int          FRAME_LEN  = 64,
    parameter int          OH_LEN     = 4,
    parameter logic [7:0]  FAS0       = 8'hF6,
    parameter logic [7:0]  FAS1       = 8'h28,
    parameter int          LOF_THRESH = 3,
    parameter int          BUF_DEPTH  = 64,
    localparam int         BUF_AW     = $clog2(BUF_DEPTH)
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_frame_data,
    input  logic       i_frame_data_valid,
    input  logic       i_frame_data_fas,
    output logic [7:0] o_pyld_data,
    output logic       o_pyld_data_valid,
    input  logic       i_pyld_data_ready,
    output logic       o_in_frame,
    output logic       o_lof,
    output logic       o_ovf
);

    localparam int         POS_W    = $clog2(FRAME_LEN);
    localparam int         BAD_W    = $clog2(LOF_THRESH + 1);
    localparam int         CNT_W    = BUF_AW + 1;
    localparam logic [7:0] PAY_MAX  = 8'(FRAME_LEN - OH_LEN);

    typedef enum logic [1:0] {
        ST_HUNT = 2'd0,
        ST_FAS2 = 2'd1,
        ST_SYNC = 2'd2
    } state_t;

    // Handshake: a payload byte transfers on every clock edge where
    // o_pyld_data_valid and i_pyld_data_ready are both high; the line side has no
    // backpressure and i_frame_data_valid simply qualifies each line byte.

    state_t             state_q, state_d;
    logic [POS_W-1:0]   pos_q;
    logic [BAD_W-1:0]   bad_cnt_q;
    logic               frame_bad_q;
    logic [7:0]         n_q;
    logic               lof_q;
    logic               ovf_q;

    logic               at_pos0, at_pos1, at_pos2, at_pay;
    logic               fas1_bad;
    logic               lof_hit;
    logic [7:0]         idx;
    logic               lof_set;
    logic               wr_req;

    logic [7:0]         mem [BUF_DEPTH];
    logic [BUF_AW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic               full, push, pop;

    assign at_pos0  = (pos_q == POS_W'(0));
    assign at_pos1  = (pos_q == POS_W'(1));
    assign at_pos2  = (pos_q == POS_W'(2));
    assign at_pay   = (pos_q >= POS_W'(OH_LEN));
    assign idx      = 8'(pos_q) - 8'(OH_LEN);
    // The frame is judged on both FAS bytes; pos1 carries the verdict.
    assign fas1_bad = frame_bad_q | (i_frame_data != FAS1);
    assign lof_hit  = at_pos1 && fas1_bad && (bad_cnt_q == BAD_W'(LOF_THRESH - 1));

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state_q <= ST_HUNT;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (i_frame_data_valid) begin
            case (state_q)
                ST_HUNT: if (i_frame_data_fas && i_frame_data == FAS0) state_d = ST_FAS2;
                ST_FAS2: state_d = (i_frame_data == FAS1) ? ST_SYNC : ST_HUNT;
                ST_SYNC: if (lof_hit) state_d = ST_HUNT;
                default: state_d = ST_HUNT;
            endcase
        end
    end

    // Output logic
    always_comb begin
        o_in_frame = (state_q == ST_SYNC);
        lof_set    = i_frame_data_valid && (state_q == ST_SYNC) && lof_hit;
        wr_req     = i_frame_data_valid && (state_q == ST_SYNC) && at_pay
                     && !frame_bad_q && (idx < n_q);
    end

    // Frame position, FAS verdict and payload length tracking
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pos_q       <= '0;
            bad_cnt_q   <= '0;
            frame_bad_q <= 1'b0;
            n_q         <= '0;
        end else if (i_frame_data_valid) begin
            if (state_q == ST_FAS2 && i_frame_data == FAS1) begin
                pos_q       <= POS_W'(2);
                bad_cnt_q   <= '0;
                frame_bad_q <= 1'b0;
            end else if (state_q == ST_SYNC) begin
                pos_q <= (pos_q == POS_W'(FRAME_LEN - 1)) ? '0 : pos_q + POS_W'(1);
                if (at_pos0) frame_bad_q <= (i_frame_data != FAS0);
                if (at_pos1) begin
                    frame_bad_q <= fas1_bad;
                    if (!fas1_bad)    bad_cnt_q <= '0;
                    else if (lof_hit) bad_cnt_q <= '0;
                    else              bad_cnt_q <= bad_cnt_q + BAD_W'(1);
                end
                if (at_pos2) n_q <= (i_frame_data > PAY_MAX) ? PAY_MAX : i_frame_data;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) lof_q <= 1'b0;
        else       lof_q <= lof_set;
    end
    assign o_lof = lof_q;

    // Payload FIFO: a pop in the same cycle frees the slot for a push when full
    assign o_pyld_data_valid = (count_q != '0);
    assign full              = (count_q == CNT_W'(BUF_DEPTH));
    assign pop               = o_pyld_data_valid && i_pyld_data_ready;
    assign push              = wr_req && (!full || pop);
    assign o_pyld_data       = o_pyld_data_valid ? mem[rd_ptr_q] : 8'h00;

    always_ff @(posedge i_clk) begin
        if (push) mem[wr_ptr_q] <= i_frame_data;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + BUF_AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + BUF_AW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
            if (wr_req && full && !pop) ovf_q <= 1'b1;
        end
    end
    assign o_ovf = ovf_q;

endmodule
